// File: rtl/proc_pkg.sv
// Shared opcode constants, FSM state encoding and control-output bundle for the
// multicycle processor control path.
package proc_pkg;

  localparam logic [5:0] OP_ADD  = 6'h00;
  localparam logic [5:0] OP_SUB  = 6'h01;
  localparam logic [5:0] OP_ADDI = 6'h02;
  localparam logic [5:0] OP_LW   = 6'h10;
  localparam logic [5:0] OP_SW   = 6'h11;
  localparam logic [5:0] OP_BEQ  = 6'h20;
  localparam logic [5:0] OP_J    = 6'h21;
  localparam logic [5:0] OP_HALT = 6'h3F;

  localparam logic [1:0] PC_SRC_INC    = 2'd0;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;

  typedef enum logic [2:0] {
    ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALT, ST_TRAP
  } state_t;

  // Outputs that depend only on the state and latched opcode.
  typedef struct packed {
    logic       imem_req;
    logic       dmem_req;
    logic       dmem_we;
    logic [2:0] alu_op;
    logic       alu_src_imm;
    logic       reg_we;
    logic       reg_dst_rt;
    logic       mem_to_reg;
    logic       halted;
    logic       trap;
  } ctrl_t;

  function automatic logic op_legal(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J, OP_HALT: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic ctrl_t state_ctrl(input state_t st, input logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (st)
      ST_FETCH: c.imem_req = 1'b1;
      ST_EXEC: begin
        c.alu_op      = ((op == OP_SUB) || (op == OP_BEQ)) ? ALU_SUB : ALU_ADD;
        c.alu_src_imm = (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
      end
      ST_MEM: begin
        c.dmem_req = 1'b1;
        c.dmem_we  = (op == OP_SW);
      end
      ST_WB: begin
        c.reg_we     = 1'b1;
        c.reg_dst_rt = (op == OP_ADDI) || (op == OP_LW);
        c.mem_to_reg = (op == OP_LW);
      end
      ST_HALT: c.halted = 1'b1;
      ST_TRAP: c.trap   = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/control_fsm_if.sv
// Instruction- and data-memory handshakes: req is held until the matching ready
// is seen high in the same cycle; ready is ignored while req is low.
interface control_fsm_if;
  logic imem_req;
  logic imem_ready;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ready;

  modport master (output imem_req, dmem_req, dmem_we, input imem_ready, dmem_ready);
  modport slave  (input imem_req, dmem_req, dmem_we, output imem_ready, dmem_ready);
endinterface

// File: rtl/control_fsm_wait_timer.sv
// Counts consecutive un-ready cycles of a memory handshake; expired flags the
// last allowed wait cycle (a ready arriving in that cycle still wins).
module wait_timer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic waiting,
  input  logic ready,
  output logic expired
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] count;

  assign expired = waiting && !ready && (count == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n)                count <= '0;
    else if (!waiting || ready) count <= '0;
    else                        count <= count + 8'd1;
  end

endmodule

// File: rtl/control_fsm.sv
// Multicycle control FSM: fetch, decode, execute, memory and write-back
// sequencing with handshake timeouts and absorbing HALT/TRAP states.
module control_fsm
  import proc_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [5:0]           op,
  input  logic                 zero,
  control_fsm_if.master        mem,
  output logic                 ir_we,
  output logic                 pc_we,
  output logic                 reg_we,
  output logic [1:0]           pc_src,
  output logic [2:0]           alu_op,
  output logic                 alu_src_imm,
  output logic                 reg_dst_rt,
  output logic                 mem_to_reg,
  output logic                 halted,
  output logic                 trap,
  output state_t               dbg_state
);

  state_t     state, state_nxt;
  logic [5:0] op_q, op_nxt;
  ctrl_t      ctrl;
  logic       fetching, accessing, wait_ready, timed_out;

  // Gate on the registered request so the idle cycle after reset cannot fetch.
  assign fetching   = (state == ST_FETCH) && ctrl.imem_req;
  assign accessing  = (state == ST_MEM) && ctrl.dmem_req;
  assign wait_ready = (state == ST_MEM) ? mem.dmem_ready : mem.imem_ready;

  wait_timer #(.TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .waiting (fetching || accessing),
    .ready   (wait_ready),
    .expired (timed_out)
  );

  always_comb begin
    state_nxt = state;
    op_nxt    = op_q;
    case (state)
      ST_FETCH: begin
        if (fetching && mem.imem_ready) state_nxt = ST_DECODE;
        else if (timed_out)             state_nxt = ST_TRAP;
      end
      ST_DECODE: begin
        op_nxt = op;
        if (op == OP_HALT)     state_nxt = ST_HALT;
        else if (!op_legal(op)) state_nxt = ST_TRAP;
        else                    state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        case (op_q)
          OP_LW, OP_SW:  state_nxt = ST_MEM;
          OP_BEQ, OP_J:  state_nxt = ST_FETCH;
          default:       state_nxt = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (accessing && mem.dmem_ready) state_nxt = (op_q == OP_SW) ? ST_FETCH : ST_WB;
        else if (timed_out)              state_nxt = ST_TRAP;
      end
      ST_WB:   state_nxt = ST_FETCH;
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_FETCH;
      op_q  <= '0;
      ctrl  <= '0;
    end else begin
      state <= state_nxt;
      op_q  <= op_nxt;
      ctrl  <= state_ctrl(state_nxt, op_nxt);
    end
  end

  // These strobes react to ready/zero in the same cycle, so they stay combinational.
  always_comb begin
    ir_we  = fetching && mem.imem_ready;
    pc_we  = 1'b0;
    pc_src = PC_SRC_INC;
    case (state)
      ST_EXEC: begin
        if (op_q == OP_BEQ) begin
          pc_we  = 1'b1;
          pc_src = zero ? PC_SRC_BRANCH : PC_SRC_INC;
        end else if (op_q == OP_J) begin
          pc_we  = 1'b1;
          pc_src = PC_SRC_JUMP;
        end
      end
      ST_MEM:  pc_we = accessing && mem.dmem_ready && (op_q == OP_SW);
      ST_WB:   pc_we = 1'b1;
      default: ;
    endcase
  end

  assign mem.imem_req = ctrl.imem_req;
  assign mem.dmem_req = ctrl.dmem_req;
  assign mem.dmem_we  = ctrl.dmem_we;
  assign reg_we       = ctrl.reg_we;
  assign alu_op       = ctrl.alu_op;
  assign alu_src_imm  = ctrl.alu_src_imm;
  assign reg_dst_rt   = ctrl.reg_dst_rt;
  assign mem_to_reg   = ctrl.mem_to_reg;
  assign halted       = ctrl.halted;
  assign trap         = ctrl.trap;
  assign dbg_state    = state;

endmodule

// File: tb/tb_control_fsm.sv
// Cycle-accurate bench for control_fsm: each driven cycle pushes the expected
// output vector, which a negedge monitor pops and compares.
module tb_control_fsm;
  import proc_pkg::*;

  localparam int TMO = 4;

  localparam logic [5:0] C_ADD = 6'h00, C_SUB = 6'h01, C_ADDI = 6'h02, C_LW = 6'h10;
  localparam logic [5:0] C_SW  = 6'h11, C_BEQ = 6'h20, C_J    = 6'h21, C_HALT = 6'h3F;

  logic       clk, rst_n, zero, ir_we, pc_we, reg_we, alu_src_imm, reg_dst_rt;
  logic       mem_to_reg, halted, trap;
  logic [5:0] op;
  logic [1:0] pc_src;
  logic [2:0] alu_op;
  state_t     dbg_state;

  control_fsm_if mem_if ();

  control_fsm #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem(mem_if),
    .ir_we(ir_we), .pc_we(pc_we), .reg_we(reg_we), .pc_src(pc_src), .alu_op(alu_op),
    .alu_src_imm(alu_src_imm), .reg_dst_rt(reg_dst_rt), .mem_to_reg(mem_to_reg),
    .halted(halted), .trap(trap), .dbg_state(dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] exp_q[$];
  string       tag_q[$];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // {imem_req, ir_we, dmem_req, dmem_we, pc_we, pc_src, reg_we, reg_dst_rt,
  //  mem_to_reg, alu_op, alu_src_imm, halted, trap}
  function automatic logic [15:0] vec(input logic ireq, input logic irwe, input logic dreq,
                                      input logic dwe, input logic pcwe, input logic [1:0] psrc,
                                      input logic rwe, input logic rdst, input logic m2r,
                                      input logic [2:0] aop, input logic asrc,
                                      input logic hlt, input logic trp);
    return {ireq, irwe, dreq, dwe, pcwe, psrc, rwe, rdst, m2r, aop, asrc, hlt, trp};
  endfunction

  function automatic logic [15:0] observed();
    return vec(mem_if.imem_req, ir_we, mem_if.dmem_req, mem_if.dmem_we, pc_we, pc_src,
               reg_we, reg_dst_rt, mem_to_reg, alu_op, alu_src_imm, halted, trap);
  endfunction

  function automatic logic [15:0] v_fetch(input logic r);
    return vec(1'b1, r, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic logic [15:0] v_exec(input logic [5:0] o, input logic z);
    logic [1:0] ps;
    logic       sub, imm, br;
    sub = (o == C_SUB) || (o == C_BEQ);
    imm = (o == C_ADDI) || (o == C_LW) || (o == C_SW);
    br  = (o == C_BEQ) || (o == C_J);
    ps  = (o == C_J) ? 2'd2 : ((o == C_BEQ) && z) ? 2'd1 : 2'd0;
    return vec(1'b0, 1'b0, 1'b0, 1'b0, br, ps, 1'b0, 1'b0, 1'b0, {2'b00, sub}, imm, 1'b0, 1'b0);
  endfunction

  function automatic logic [15:0] v_mem(input logic [5:0] o, input logic r);
    logic sw;
    sw = (o == C_SW);
    return vec(1'b0, 1'b0, 1'b1, sw, sw && r, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic logic [15:0] v_wb(input logic [5:0] o);
    return vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, (o == C_ADDI) || (o == C_LW),
               o == C_LW, 3'd0, 1'b0, 1'b0, 1'b0);
  endfunction

  localparam logic [15:0] V_IDLE = 16'h0000;
  localparam logic [15:0] V_HALT = 16'h0002;
  localparam logic [15:0] V_TRAP = 16'h0001;

  function automatic logic [5:0] rnd_op();
    return 6'($urandom_range(0, 63));
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic bit bench_legal(input logic [5:0] o);
    return (o == C_ADD) || (o == C_SUB) || (o == C_ADDI) || (o == C_LW) || (o == C_SW) ||
           (o == C_BEQ) || (o == C_J) || (o == C_HALT);
  endfunction

  // Scoreboard monitor
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) check(tag_q.pop_front(), observed(), exp_q.pop_front());
    end
  end

  // Driver tasks
  task automatic step(input logic ir, input logic dr, input logic [5:0] o, input logic z,
                      input logic [15:0] e, input string tag);
    @(posedge clk);
    #1;
    mem_if.imem_ready = ir;
    mem_if.dmem_ready = dr;
    op   = o;
    zero = z;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    mem_if.imem_ready = rnd_bit();
    mem_if.dmem_ready = rnd_bit();
    step(rnd_bit(), rnd_bit(), rnd_op(), rnd_bit(), V_IDLE, "rst_hold");
    rst_n = 1'b0;
    // Ready high while released but before the first request must not fetch.
    step(1'b1, 1'b1, rnd_op(), rnd_bit(), V_IDLE, "rst_release");
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_state", 16'(dbg_state), 16'(ST_FETCH));
  endtask

  task automatic absorb(input logic [15:0] v, input string tag);
    for (int i = 0; i < 3; i++) step(rnd_bit(), rnd_bit(), rnd_op(), rnd_bit(), v, tag);
  endtask

  // stuck=1: the FSM ended in HALT or TRAP and needs a reset.
  task automatic run_instr(input logic [5:0] opc, input logic z, input int fd, input int md,
                           input bit abort_mem, output bit stuck);
    stuck = 1'b0;
    for (int i = 0; i <= fd; i++) begin
      if (i == fd) begin
        step(1'b1, rnd_bit(), rnd_op(), rnd_bit(), v_fetch(1'b1), "fetch_rdy");
      end else begin
        step(1'b0, rnd_bit(), rnd_op(), rnd_bit(), v_fetch(1'b0), "fetch_wait");
        if (i == TMO - 1) begin
          absorb(V_TRAP, "fetch_trap");
          stuck = 1'b1;
          return;
        end
      end
    end
    step(rnd_bit(), rnd_bit(), opc, rnd_bit(), V_IDLE, "decode");
    if (opc == C_HALT) begin
      absorb(V_HALT, "halt");
      stuck = 1'b1;
      return;
    end
    if (!bench_legal(opc)) begin
      absorb(V_TRAP, "illegal_trap");
      stuck = 1'b1;
      return;
    end
    step(rnd_bit(), rnd_bit(), rnd_op(), z, v_exec(opc, z), "exec");
    if ((opc == C_LW) || (opc == C_SW)) begin
      for (int i = 0; i <= md; i++) begin
        if (abort_mem && (i == 2)) begin
          do_reset();
          return;
        end
        if (i == md) begin
          step(rnd_bit(), 1'b1, rnd_op(), rnd_bit(), v_mem(opc, 1'b1), "mem_rdy");
        end else begin
          step(rnd_bit(), 1'b0, rnd_op(), rnd_bit(), v_mem(opc, 1'b0), "mem_wait");
          if (i == TMO - 1) begin
            absorb(V_TRAP, "mem_trap");
            stuck = 1'b1;
            return;
          end
        end
      end
    end
    if ((opc != C_SW) && (opc != C_BEQ) && (opc != C_J))
      step(rnd_bit(), rnd_bit(), rnd_op(), rnd_bit(), v_wb(opc), "wb");
  endtask

  logic [5:0] legal_ops [7] = '{C_ADD, C_SUB, C_ADDI, C_LW, C_SW, C_BEQ, C_J};

  initial begin
    bit stuck;
    rst_n = 1'b0;
    op = '0;
    zero = 1'b0;
    mem_if.imem_ready = 1'b0;
    mem_if.dmem_ready = 1'b0;
    do_reset();

    run_instr(C_ADD,  1'b0, 0, 0, 1'b0, stuck);
    run_instr(C_SUB,  1'b1, 2, 0, 1'b0, stuck);
    run_instr(C_ADDI, 1'b0, 0, 0, 1'b0, stuck);
    run_instr(C_LW,   1'b0, 0, 3, 1'b0, stuck);
    run_instr(C_SW,   1'b0, 0, 0, 1'b0, stuck);
    run_instr(C_SW,   1'b1, 1, 1, 1'b0, stuck);
    run_instr(C_BEQ,  1'b1, 0, 0, 1'b0, stuck);
    run_instr(C_BEQ,  1'b0, 0, 0, 1'b0, stuck);
    run_instr(C_J,    1'b0, 3, 0, 1'b0, stuck);

    for (int n = 0; n < 12; n++)
      run_instr(legal_ops[$urandom_range(0, 6)], rnd_bit(), $urandom_range(0, 2),
                $urandom_range(0, 3), 1'b0, stuck);

    run_instr(C_LW, 1'b0, 0, 6, 1'b0, stuck);
    if (stuck) do_reset();
    run_instr(C_ADD, 1'b0, 6, 0, 1'b0, stuck);
    if (stuck) do_reset();
    run_instr(C_HALT, 1'b0, 0, 0, 1'b0, stuck);
    if (stuck) do_reset();
    run_instr(6'h05, 1'b0, 0, 0, 1'b0, stuck);
    if (stuck) do_reset();
    run_instr(C_SW, 1'b0, 0, 5, 1'b1, stuck);
    run_instr(C_ADDI, 1'b0, 0, 0, 1'b0, stuck);
    run_instr(C_LW, 1'b0, 1, 0, 1'b0, stuck);

    @(negedge clk);
    #1;
    check("drain", 16'(exp_q.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15: maximum wait cycles on any memory handshake before trap; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 op  input  6  opcode field, instruction bits 23:18, from the field decoder.
REQ-005 zero  input  1  ALU equality flag, valid in EXEC.
REQ-006 imem_req  output  1  instruction fetch request.
REQ-007 imem_ready  input  1  fetch data valid this cycle.
REQ-008 dmem_req / dmem_we  output  1 each  data-memory request / write enable.
REQ-009 dmem_ready  input  1  data access complete this cycle.
REQ-010 ir_we, pc_we, reg_we  output  1 each  instruction-register, PC and register-file write strobes.
REQ-011 pc_src  output  2  PC mux: 0=PC+1, 1=PC+imm (branch), 2=imm (jump).
REQ-012 alu_op  output  3  0=ADD, 1=SUB, others reserved and never driven.
REQ-013 alu_src_imm, reg_dst_rt, mem_to_reg  output  1 each  ALU B=immediate; write Rt instead of Rd; write-back from memory.
REQ-014 halted, trap  output  1 each  sticky status flags.

Function
REQ-015 Opcodes: ADD 0x00, SUB 0x01, ADDI 0x02, LW 0x10, SW 0x11, BEQ 0x20, J 0x21, HALT 0x3F; any other value is illegal.
REQ-016 States: FETCH, DECODE, EXEC, MEM, WB, HALT, TRAP; one state per cycle except FETCH/MEM, which hold while waiting.
REQ-017 FETCH: imem_req=1; on imem_ready, ir_we=1 for that cycle, then DECODE.
REQ-018 DECODE: HALT -> HALT; illegal -> TRAP; otherwise -> EXEC.
REQ-019 EXEC ADD/SUB/ADDI: alu_op per opcode; alu_src_imm=1 for ADDI; then WB.
REQ-020 EXEC LW/SW: alu_op=ADD, alu_src_imm=1; then MEM.
REQ-021 EXEC BEQ: alu_op=SUB; pc_we=1 with pc_src=1 when zero=1, else pc_src=0; then FETCH.
REQ-022 EXEC J: pc_we=1, pc_src=2; then FETCH.
REQ-023 MEM: dmem_req=1, dmem_we=1 for SW; on dmem_ready, SW pulses pc_we with pc_src=0 and goes to FETCH, LW goes to WB.
REQ-024 WB: reg_we=1 and pc_we=1 with pc_src=0; reg_dst_rt=1 for ADDI/LW; mem_to_reg=1 for LW; then FETCH.
REQ-025 Zero-wait latency in cycles: R-type/ADDI 4, LW 5, SW 4, BEQ 3, J 3.
REQ-026 Wait counter clears on entry to FETCH/MEM and increments each cycle without ready; reaching MEM_TIMEOUT -> TRAP; ready on the timeout cycle wins.
REQ-027 HALT and TRAP are absorbing: all strobes and requests 0; halted=1 (HALT) or trap=1 (TRAP); left only by reset.
REQ-028 Every strobe is 1 for exactly one cycle per instruction; every output not named active for the current state is 0.
REQ-029 op is sampled only in DECODE and latched; a change of op after DECODE does not alter the sequence.

Reset
REQ-030 rst_n=0 at a clock edge -> state FETCH, wait counter 0, latched op 0, halted=0, trap=0, all strobes/requests 0, including mid-handshake; imem_req rises the first cycle after rst_n=1.

Structure
REQ-031 Opcode constants, the state enumeration and the pc_src/alu_op encodings reside in shared package proc_pkg.
REQ-032 The wait counter with its timeout compare forms one sub-module, wait_timer; all other logic is flat.

Verification
REQ-033 ADD with zero-wait memory: strobes are ir_we@1, reg_we+pc_we@4 with reg_dst_rt=0, and the next imem_req is at cycle 5.
REQ-034 LW with dmem_ready delayed 3 cycles: dmem_req held for 4 cycles, then WB asserts reg_we, mem_to_reg=1, reg_dst_rt=1.
REQ-035 BEQ with zero=1 -> pc_src=1 with pc_we at cycle 3; repeated with zero=0 -> pc_src=0.
REQ-036 imem_ready held 0 with MEM_TIMEOUT=4 -> trap=1 after 4 wait cycles and stays set; rst_n=0 clears it.
REQ-037 op=0x3F -> halted=1 after DECODE, with no further imem_req; op=0x05 -> trap=1.
REQ-038 rst_n asserted during MEM of SW -> dmem_req=0 on the next cycle and the FSM restarts in FETCH.
